// File: rtl/score_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_pkg : shared types, glyph table and BCD helpers for the scores  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package score_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    CELL_NONE = 3'd0,
    CELL_AT   = 3'd1,
    CELL_AU   = 3'd2,
    CELL_BT   = 3'd3,
    CELL_BU   = 3'd4
  } cell_e;

  // Bit order {a,b,c,d,e,f,g}; anything outside 0-9 lights nothing.
  function automatic logic [6:0] seg_pattern(input logic [BCD_W-1:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [2*BCD_W-1:0] s);
    return ({3'b000, s[7:4]} * 7'd10) + {3'b000, s[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_glyph : seven-segment hit test for one pixel inside a digit cell |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_glyph
  import score_pkg::*;
#(
  parameter logic [9:0] DIGIT_W = 10'd16,
  parameter logic [9:0] DIGIT_H = 10'd32,
  parameter logic [9:0] STROKE  = 10'd4
) (
  input  logic [9:0]       lx,
  input  logic [9:0]       ly,
  input  logic [BCD_W-1:0] digit,
  input  logic             blank,
  output logic             hit
);

  localparam logic [9:0] H2          = DIGIT_H >> 1;
  localparam logic [9:0] HALF_STROKE = STROKE >> 1;

  logic       on_left;
  logic       on_right;
  logic       on_upper;
  logic [6:0] region;
  logic [6:0] lit_segs;

  always_comb begin
    on_left  = (lx < STROKE);
    on_right = (lx >= DIGIT_W - STROKE);
    on_upper = (ly < H2);
    region   = {ly < STROKE,                                      // a
                on_right && on_upper,                             // b
                on_right && !on_upper,                            // c
                ly >= DIGIT_H - STROKE,                           // d
                on_left && !on_upper,                             // e
                on_left && on_upper,                              // f
                (ly >= H2 - HALF_STROKE) && (ly < H2 + HALF_STROKE)}; // g
    lit_segs = seg_pattern(digit) & region;
    hit      = !blank && (lit_segs != 7'd0);
  end

endmodule
`default_nettype wire

// File: rtl/score_render.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_render : BCD score keeping, game-over detection and 2-stage     |
// | seven-segment score overlay with winner blink. Rev 1.0               |
// +----------------------------------------------------------------------+
module score_render
  import score_pkg::*;
#(
  parameter logic [9:0] SCOREA_X  = 10'd256,
  parameter logic [9:0] SCOREB_X  = 10'd352,
  parameter logic [9:0] SCORE_Y   = 10'd16,
  parameter logic [9:0] DIGIT_W   = 10'd16,
  parameter logic [9:0] DIGIT_H   = 10'd32,
  parameter logic [9:0] STROKE    = 10'd4,
  parameter logic [9:0] DIGIT_GAP = 10'd4,
  parameter logic [6:0] WINSCORE  = 7'd11,
  parameter int         BLINKBITS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       newgame,
  input  logic       pointA,
  input  logic       pointB,
  input  logic       vsync,
  input  logic       videoActive,
  input  logic [9:0] realx,
  input  logic [9:0] realy,
  output logic       score_scan,
  output logic       game_over,
  output logic       winner,
  output logic [7:0] scoreA,
  output logic [7:0] scoreB
);

  localparam logic [9:0] A_TENS_X  = SCOREA_X;
  localparam logic [9:0] A_UNITS_X = SCOREA_X + DIGIT_W + DIGIT_GAP;
  localparam logic [9:0] B_TENS_X  = SCOREB_X;
  localparam logic [9:0] B_UNITS_X = SCOREB_X + DIGIT_W + DIGIT_GAP;
  localparam logic [BLINKBITS-1:0] FRAME_ONE = {{(BLINKBITS-1){1'b0}}, 1'b1};

  // Range check first; the subtraction is only meaningful once v >= lo.
  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] span);
    return (v >= lo) && ((v - lo) < span);
  endfunction

  logic [2*BCD_W-1:0]   score_a_q, score_a_d;
  logic [2*BCD_W-1:0]   score_b_q, score_b_d;
  logic                 game_over_q, game_over_d;
  logic                 winner_q, winner_d;
  logic                 vsync_prev_q, vsync_prev_d;
  logic [BLINKBITS-1:0] frame_q, frame_d;
  cell_e                s1_cell_q, s1_cell_d;
  logic [9:0]           s1_lx_q, s1_lx_d;
  logic [9:0]           s1_ly_q, s1_ly_d;
  logic [BCD_W-1:0]     s1_digit_q, s1_digit_d;
  logic                 s1_blank_q, s1_blank_d;
  logic                 score_scan_q, score_scan_d;

  logic [7:0] a_bin;
  logic [7:0] b_bin;
  logic       in_y;
  logic       glyph_hit;
  logic       winner_cell;
  logic       blink;

  assign a_bin = {1'b0, bcd_to_bin(score_a_q)};
  assign b_bin = {1'b0, bcd_to_bin(score_b_q)};

  always_comb begin
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    if (!game_over_q) begin
      if (pointA) score_a_d = bcd_inc(score_a_q);
      if (pointB) score_b_d = bcd_inc(score_b_q);
      // Judged on the registered scores, so game_over trails the update by one clock.
      if ((a_bin >= {1'b0, WINSCORE}) && (a_bin >= b_bin + 8'd2)) begin
        game_over_d = 1'b1;
        winner_d    = 1'b0;
      end else if ((b_bin >= {1'b0, WINSCORE}) && (b_bin >= a_bin + 8'd2)) begin
        game_over_d = 1'b1;
        winner_d    = 1'b1;
      end
    end
    if (newgame) begin
      score_a_d   = '0;
      score_b_d   = '0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
    end
  end

  always_comb begin
    vsync_prev_d = vsync;
    frame_d      = (vsync_prev_q && !vsync) ? frame_q + FRAME_ONE : frame_q;
  end

  always_comb begin
    s1_cell_d  = CELL_NONE;
    s1_lx_d    = '0;
    s1_ly_d    = '0;
    s1_digit_d = '0;
    s1_blank_d = 1'b0;
    in_y       = in_span(realy, SCORE_Y, DIGIT_H);
    if (videoActive && in_y) begin
      if (in_span(realx, A_TENS_X, DIGIT_W)) begin
        s1_cell_d  = CELL_AT;
        s1_lx_d    = realx - A_TENS_X;
        s1_digit_d = score_a_q[7:4];
        s1_blank_d = (score_a_q[7:4] == 4'd0);
      end else if (in_span(realx, A_UNITS_X, DIGIT_W)) begin
        s1_cell_d  = CELL_AU;
        s1_lx_d    = realx - A_UNITS_X;
        s1_digit_d = score_a_q[3:0];
      end else if (in_span(realx, B_TENS_X, DIGIT_W)) begin
        s1_cell_d  = CELL_BT;
        s1_lx_d    = realx - B_TENS_X;
        s1_digit_d = score_b_q[7:4];
        s1_blank_d = (score_b_q[7:4] == 4'd0);
      end else if (in_span(realx, B_UNITS_X, DIGIT_W)) begin
        s1_cell_d  = CELL_BU;
        s1_lx_d    = realx - B_UNITS_X;
        s1_digit_d = score_b_q[3:0];
      end
      if (s1_cell_d != CELL_NONE) s1_ly_d = realy - SCORE_Y;
    end
  end

  seg7_glyph #(
    .DIGIT_W (DIGIT_W),
    .DIGIT_H (DIGIT_H),
    .STROKE  (STROKE)
  ) u_glyph (
    .lx    (s1_lx_q),
    .ly    (s1_ly_q),
    .digit (s1_digit_q),
    .blank (s1_blank_q),
    .hit   (glyph_hit)
  );

  always_comb begin
    winner_cell  = winner_q ? ((s1_cell_q == CELL_BT) || (s1_cell_q == CELL_BU))
                            : ((s1_cell_q == CELL_AT) || (s1_cell_q == CELL_AU));
    blink        = game_over_q && frame_q[BLINKBITS-1] && winner_cell;
    score_scan_d = (s1_cell_q != CELL_NONE) && glyph_hit && !blink;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      score_a_q    <= '0;
      score_b_q    <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      vsync_prev_q <= 1'b0;
      frame_q      <= '0;
      s1_cell_q    <= CELL_NONE;
      s1_lx_q      <= '0;
      s1_ly_q      <= '0;
      s1_digit_q   <= '0;
      s1_blank_q   <= 1'b0;
      score_scan_q <= 1'b0;
    end else begin
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      vsync_prev_q <= vsync_prev_d;
      frame_q      <= frame_d;
      s1_cell_q    <= s1_cell_d;
      s1_lx_q      <= s1_lx_d;
      s1_ly_q      <= s1_ly_d;
      s1_digit_q   <= s1_digit_d;
      s1_blank_q   <= s1_blank_d;
      score_scan_q <= score_scan_d;
    end
  end

  assign score_scan = score_scan_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign scoreA     = score_a_q;
  assign scoreB     = score_b_q;

endmodule
`default_nettype wire

// File: tb/tb_score_render.sv
`default_nettype none
// Directed bench for score_render: scoring, game over, saturation, rendering and blink.
module tb_score_render;

  logic       clk = 1'b0;
  logic       reset_n, newgame, point_a, point_b, vsync, video_active;
  logic [9:0] realx, realy;
  logic       score_scan, game_over, winner;
  logic [7:0] score_a, score_b;
  logic       sat_scan, sat_go, sat_win;
  logic [7:0] sat_a, sat_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  score_render dut (
    .clk(clk), .reset_n(reset_n), .newgame(newgame), .pointA(point_a), .pointB(point_b),
    .vsync(vsync), .videoActive(video_active), .realx(realx), .realy(realy),
    .score_scan(score_scan), .game_over(game_over), .winner(winner),
    .scoreA(score_a), .scoreB(score_b)
  );

  score_render #(.WINSCORE(7'd127)) dut_sat (
    .clk(clk), .reset_n(reset_n), .newgame(newgame), .pointA(point_a), .pointB(point_b),
    .vsync(vsync), .videoActive(video_active), .realx(realx), .realy(realy),
    .score_scan(sat_scan), .game_over(sat_go), .winner(sat_win),
    .scoreA(sat_a), .scoreB(sat_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic a, input logic b, input logic ng);
    point_a = a;
    point_b = b;
    newgame = ng;
    tick();
    point_a = 1'b0;
    point_b = 1'b0;
    newgame = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input logic act);
    realx        = 10'(x);
    realy        = 10'(y);
    video_active = act;
    tick();
    tick();
  endtask

  int         lit;
  logic       bad;
  logic [4:0] fm;

  initial begin
    reset_n = 1'b0; newgame = 1'b0; point_a = 1'b0; point_b = 1'b0;
    vsync = 1'b1; video_active = 1'b0; realx = '0; realy = '0;
    tick();
    tick();
    check("rst_scoreA", 32'(score_a), 32'h00);
    check("rst_scoreB", 32'(score_b), 32'h00);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_scan", 32'(score_scan), 32'd0);
    reset_n = 1'b1;
    tick();

    // Three A points, each visible right after its sampling edge.
    pulse(1'b1, 1'b0, 1'b0); check("a_pt1", 32'(score_a), 32'h01); tick();
    pulse(1'b1, 1'b0, 1'b0); check("a_pt2", 32'(score_a), 32'h02); tick();
    pulse(1'b1, 1'b0, 1'b0); check("a_pt3", 32'(score_a), 32'h03); tick();
    check("a_pt_scoreB", 32'(score_b), 32'h00);
    check("a_pt_go", 32'(game_over), 32'd0);

    // B to 10, then A to 11 (lead 1), then A to 12 (lead 2).
    pulse(1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 10; i++) begin pulse(1'b0, 1'b1, 1'b0); tick(); end
    check("b_ten", 32'(score_b), 32'h10);
    for (int i = 0; i < 11; i++) begin
      pulse(1'b1, 1'b0, 1'b0); tick();
      check("go_early", 32'(game_over), 32'd0);
    end
    check("a_eleven", 32'(score_a), 32'h11);
    pulse(1'b1, 1'b0, 1'b0);
    check("a_twelve", 32'(score_a), 32'h12);
    check("go_lag", 32'(game_over), 32'd0);
    tick();
    check("go_set", 32'(game_over), 32'd1);
    check("winner_a", 32'(winner), 32'd0);
    pulse(1'b0, 1'b1, 1'b0); tick();
    check("b_ignored", 32'(score_b), 32'h10);
    check("a_frozen", 32'(score_a), 32'h12);

    // newgame clears; simultaneous points; newgame beats a point.
    pulse(1'b0, 1'b0, 1'b1);
    check("ng_scoreA", 32'(score_a), 32'h00);
    check("ng_go", 32'(game_over), 32'd0);
    pulse(1'b1, 1'b1, 1'b0);
    check("both_a", 32'(score_a), 32'h01);
    check("both_b", 32'(score_b), 32'h01);
    tick();
    pulse(1'b0, 1'b1, 1'b1);
    check("ng_pt_a", 32'(score_a), 32'h00);
    check("ng_pt_b", 32'(score_b), 32'h00);

    // Render with A = 07, B = 00.
    for (int i = 0; i < 7; i++) begin pulse(1'b1, 1'b0, 1'b0); tick(); end
    check("a_seven", 32'(score_a), 32'h07);
    pixel(0, 0, 1'b1);
    realx = 10'd276; realy = 10'd17;
    tick();
    check("lat_stage1", 32'(score_scan), 32'd0);
    tick();
    check("seg_a_7", 32'(score_scan), 32'd1);
    pixel(276, 32, 1'b1); check("no_g_7", 32'(score_scan), 32'd0);
    pixel(276, 17, 1'b0); check("inactive", 32'(score_scan), 32'd0);
    pixel(372, 17, 1'b1); check("b0_seg_a", 32'(score_scan), 32'd1);
    pixel(372, 47, 1'b1); check("b0_seg_d_edge", 32'(score_scan), 32'd1);
    pixel(372, 48, 1'b1); check("b0_below", 32'(score_scan), 32'd0);
    pixel(387, 20, 1'b1); check("b0_seg_b_edge", 32'(score_scan), 32'd1);
    pixel(388, 20, 1'b1); check("b0_right", 32'(score_scan), 32'd0);
    pixel(362, 17, 1'b1); check("b_tens_blank", 32'(score_scan), 32'd0);

    // Tens cell of A (leading zero) must stay dark.
    pixel(0, 0, 1'b0);
    lit = 0;
    video_active = 1'b1;
    for (int y = 16; y < 48; y++)
      for (int x = 256; x < 272; x++) begin
        realx = 10'(x); realy = 10'(y); tick(); lit += int'(score_scan);
      end
    video_active = 1'b0;
    tick(); lit += int'(score_scan);
    tick(); lit += int'(score_scan);
    check("a_tens_dark", 32'(lit), 32'd0);

    // Units 7 = a(64) + b(48 outside a) + c(64) lit pixels.
    lit = 0;
    video_active = 1'b1;
    for (int y = 16; y < 48; y++)
      for (int x = 276; x < 292; x++) begin
        realx = 10'(x); realy = 10'(y); tick(); lit += int'(score_scan);
      end
    video_active = 1'b0;
    tick(); lit += int'(score_scan);
    tick(); lit += int'(score_scan);
    check("a_units_7_count", 32'(lit), 32'd176);

    // B wins 11-0; B blinks with frame counter MSB, A always drawn.
    pulse(1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 11; i++) begin pulse(1'b0, 1'b1, 1'b0); tick(); end
    check("b_eleven", 32'(score_b), 32'h11);
    check("go_b", 32'(game_over), 32'd1);
    check("winner_b", 32'(winner), 32'd1);
    fm = 5'd0;
    for (int f = 0; f < 32; f++) begin
      pixel(384, 17, 1'b1); check("blink_b_units", 32'(score_scan), 32'(!fm[4]));
      pixel(364, 17, 1'b1); check("blink_b_tens", 32'(score_scan), 32'(!fm[4]));
      pixel(276, 17, 1'b1); check("steady_a", 32'(score_scan), 32'd1);
      vsync = 1'b0; tick();
      vsync = 1'b1; tick();
      fm = fm + 5'd1;
    end

    // Saturation on the instance whose win threshold is unreachable.
    pulse(1'b0, 1'b0, 1'b1); tick();
    bad = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      if (sat_b == 8'h00) bad = 1'b1;
      if (i == 99) check("sat_at_99", 32'(sat_b), 32'h99);
      tick();
    end
    check("sat_final", 32'(sat_b), 32'h99);
    check("sat_no_wrap", 32'(bad), 32'd0);
    check("sat_no_go", 32'(sat_go), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
